smp_read_ctrl: RTL and testbench



---
 rtl/smp_read_ctrl_pkg.sv | 13 +
 rtl/smp_read_ctrl_if.sv | 34 +++
 rtl/smp_read_ctrl.sv | 133 +++++++++++++
 tb/tb_smp_read_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/smp_read_ctrl_pkg.sv
// Shared ILA readout definitions: controller state encoding and BRAM read latency.
package smp_read_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StIdle   = 2'd0;
   localparam state_t StFetch0 = 2'd1;
   localparam state_t StActive = 2'd2;

   // Cycles from an address/enable pair to valid BRAM read data.
   localparam int unsigned RdLatency = 1;

endpackage

// File: rtl/smp_read_ctrl_if.sv
// Readout bus between the capture BRAM / splitter side and the readout controller.
interface smp_read_ctrl_if #(
   parameter int unsigned addr_width   = 12,
   parameter int unsigned sample_width = 24
);

   logic                    i_start_read;
   logic                    i_abort;
   logic [addr_width-1:0]   i_trigger_addr;
   logic [addr_width-1:0]   i_pretrigger;
   logic [addr_width:0]     i_sample_count;
   logic                    i_rd;
   logic [addr_width-1:0]   o_ram_addr;
   logic                    o_ram_re;
   logic [sample_width-1:0] i_ram_data;
   logic [sample_width-1:0] o_ram_sample;
   logic                    o_read_active;
   logic                    o_done;

   // Controller view: it masters the BRAM read port and the splitter sample input.
   modport master (
      input  i_start_read, i_abort, i_trigger_addr, i_pretrigger, i_sample_count, i_rd,
      input  i_ram_data,
      output o_ram_addr, o_ram_re, o_ram_sample, o_read_active, o_done
   );

   // Surrounding logic view (BRAM, splitter, capture control).
   modport slave (
      output i_start_read, i_abort, i_trigger_addr, i_pretrigger, i_sample_count, i_rd,
      output i_ram_data,
      input  o_ram_addr, o_ram_re, o_ram_sample, o_read_active, o_done
   );

endinterface

// File: rtl/smp_read_ctrl.sv
// ILA capture-buffer readout: walks the circular buffer from the oldest pre-trigger
// sample, presenting one registered sample at a time to the nibble splitter.
module smp_read_ctrl
   import smp_read_ctrl_pkg::*;
#(
   parameter int unsigned addr_width   = 12,
   parameter int unsigned sample_width = 24
) (
   input logic             i_clk_ILA,
   input logic             i_reset,
   smp_read_ctrl_if.master bus
);

   state_t                  state_q, state_d;
   logic                    fetch_cnt_q, fetch_cnt_d;
   logic [addr_width-1:0]   addr_q, addr_d;
   logic                    re_q, re_d;
   logic [addr_width:0]     count_q, count_d;
   logic [addr_width:0]     cons_q, cons_d;
   logic                    active_q, active_d;
   logic                    done_q, done_d;
   logic [RdLatency-1:0]    pend_q, pend_d;
   logic [sample_width-1:0] sample_q, sample_d;

   // Control FSM: start latching, FETCH0 wait, per-consume prefetch and termination.
   always_comb begin
      state_d     = state_q;
      fetch_cnt_d = fetch_cnt_q;
      addr_d      = addr_q;
      re_d        = 1'b0;
      count_d     = count_q;
      cons_d      = cons_q;
      active_d    = active_q;
      done_d      = 1'b0;

      if (bus.i_abort) begin
         state_d     = StIdle;
         fetch_cnt_d = 1'b0;
         active_d    = 1'b0;
         done_d      = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.i_start_read) begin
                  if (bus.i_sample_count == '0) begin
                     done_d = 1'b1;
                  end else begin
                     // Oldest pre-trigger sample; modular subtraction handles the wrap.
                     addr_d      = bus.i_trigger_addr - bus.i_pretrigger;
                     count_d     = bus.i_sample_count;
                     cons_d      = '0;
                     re_d        = 1'b1;
                     fetch_cnt_d = 1'b0;
                     state_d     = StFetch0;
                  end
               end
            end
            StFetch0: begin
               if (fetch_cnt_q) begin
                  // Sample 0 lands in sample_q this edge; prefetch sample 1 alongside.
                  fetch_cnt_d = 1'b0;
                  state_d     = StActive;
                  active_d    = 1'b1;
                  addr_d      = addr_q + 1'b1;
                  re_d        = 1'b1;
               end else begin
                  fetch_cnt_d = 1'b1;
               end
            end
            StActive: begin
               if (bus.i_rd) begin
                  cons_d = cons_q + 1'b1;
                  if (cons_d == count_q) begin
                     state_d  = StIdle;
                     active_d = 1'b0;
                     done_d   = 1'b1;
                  end else if (cons_d < count_q) begin
                     addr_d = addr_q + 1'b1;
                     re_d   = 1'b1;
                  end
               end
            end
            default: begin
               state_d  = StIdle;
               active_d = 1'b0;
            end
         endcase
      end
   end

   // Delayed-enable capture: take BRAM data once the read latency has elapsed.
   always_comb begin
      pend_d   = (pend_q << 1) | RdLatency'(re_q);
      sample_d = sample_q;
      if (pend_q[RdLatency-1]) begin
         sample_d = bus.i_ram_data;
      end
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge i_clk_ILA or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= StIdle;
         fetch_cnt_q <= 1'b0;
         addr_q      <= '0;
         re_q        <= 1'b0;
         count_q     <= '0;
         cons_q      <= '0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
         pend_q      <= '0;
         sample_q    <= '0;
      end else begin
         state_q     <= state_d;
         fetch_cnt_q <= fetch_cnt_d;
         addr_q      <= addr_d;
         re_q        <= re_d;
         count_q     <= count_d;
         cons_q      <= cons_d;
         active_q    <= active_d;
         done_q      <= done_d;
         pend_q      <= pend_d;
         sample_q    <= sample_d;
      end
   end

   assign bus.o_ram_addr    = addr_q;
   assign bus.o_ram_re      = re_q;
   assign bus.o_ram_sample  = sample_q;
   assign bus.o_read_active = active_q;
   assign bus.o_done        = done_q;

endmodule

// File: tb/tb_smp_read_ctrl.sv
// Scoreboard bench for smp_read_ctrl with a small BRAM model and a 16-entry buffer.
module tb_smp_read_ctrl;

   localparam int unsigned AW    = 4;
   localparam int unsigned SW    = 24;
   localparam int unsigned Depth = 1 << AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   smp_read_ctrl_if #(.addr_width(AW), .sample_width(SW)) bus ();

   smp_read_ctrl #(.addr_width(AW), .sample_width(SW)) dut (
      .i_clk_ILA (clk),
      .i_reset   (rst_n),
      .bus       (bus)
   );

   logic [SW-1:0] mem [Depth];
   logic [AW-1:0] exp_addr_q [$];
   logic [SW-1:0] exp_smp_q  [$];
   logic          re_prev = 1'b0;
   int            n_vec = 0;
   int            n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // BRAM model: one-cycle registered read.
   always @(posedge clk) begin
      if (bus.o_ram_re) bus.i_ram_data <= mem[bus.o_ram_addr];
   end

   // Read-address scoreboard and single-cycle enable check.
   always @(negedge clk) begin
      if (bus.o_ram_re) begin
         check_eq("re_one_cycle", 32'(re_prev), 32'd0);
         if (exp_addr_q.size() == 0) check_eq("unexpected_read", exp_addr_q.size(), 1);
         else check_eq("read_addr", 32'(bus.o_ram_addr), 32'(exp_addr_q.pop_front()));
      end
      re_prev <= bus.o_ram_re;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_addr"},   32'(bus.o_ram_addr), 32'd0);
      check_eq({tag, "_re"},     32'(bus.o_ram_re), 32'd0);
      check_eq({tag, "_sample"}, 32'(bus.o_ram_sample), 32'd0);
      check_eq({tag, "_active"}, 32'(bus.o_read_active), 32'd0);
      check_eq({tag, "_done"},   32'(bus.o_done), 32'd0);
   endtask

   // One readout; abort_at/rst_at (1-based i_rd index, 0 = never) cut it short.
   task automatic run_read(input logic [AW-1:0] trig, input logic [AW-1:0] pre,
                           input logic [AW:0] cnt, input int gap, input int abort_at,
                           input int rst_at);
      logic [AW-1:0] st;
      logic [AW-1:0] a;
      int            last;
      int            lat;
      st   = trig - pre;
      last = int'(cnt);
      if (abort_at != 0) last = abort_at;
      if (rst_at != 0) last = rst_at;
      if (cnt != 0) begin
         for (int i = 0; i <= last; i++) begin
            a = st + AW'(i);
            exp_addr_q.push_back(a);
            exp_smp_q.push_back(mem[a]);
         end
      end
      tick();
      bus.i_trigger_addr = trig;
      bus.i_pretrigger   = pre;
      bus.i_sample_count = cnt;
      bus.i_start_read   = 1'b1;
      tick();
      bus.i_start_read   = 1'b0;
      // Later input changes must not disturb the latched readout.
      bus.i_trigger_addr = AW'($urandom);
      bus.i_pretrigger   = AW'($urandom);
      bus.i_sample_count = (AW + 1)'($urandom_range(1, Depth));
      if (cnt == 0) begin
         check_eq("zero_done", 32'(bus.o_done), 32'd1);
         for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("zero_active", 32'(bus.o_read_active), 32'd0);
         end
         check_eq("zero_done_pulse", 32'(bus.o_done), 32'd0);
         return;
      end
      check_eq("no_early_done", 32'(bus.o_done), 32'd0);
      lat = 1;
      while (!bus.o_read_active && lat < 10) begin
         tick();
         lat++;
      end
      check_eq("active_latency", lat, 3);
      check_eq("sample0", 32'(bus.o_ram_sample), 32'(exp_smp_q.pop_front()));
      for (int j = 1; j <= int'(cnt); j++) begin
         repeat (gap) tick();
         if (j == rst_at) begin
            #2;
            rst_n = 1'b0;
            #1;
            check_idle_outputs("async_rst");
            exp_addr_q.delete();
            exp_smp_q.delete();
            tick();
            rst_n = 1'b1;
            return;
         end
         check_eq("sample_before_rd", 32'(bus.o_ram_sample), 32'(exp_smp_q.pop_front()));
         bus.i_rd    = 1'b1;
         bus.i_abort = (j == abort_at);
         tick();
         bus.i_rd    = 1'b0;
         bus.i_abort = 1'b0;
         if (j == abort_at || j == int'(cnt)) begin
            check_eq("end_done", 32'(bus.o_done), 32'd1);
            check_eq("end_active", 32'(bus.o_read_active), 32'd0);
            tick();
            check_eq("done_single", 32'(bus.o_done), 32'd0);
            check_eq("end_no_read", 32'(bus.o_ram_re), 32'd0);
            break;
         end
         check_eq("mid_done", 32'(bus.o_done), 32'd0);
         check_eq("mid_active", 32'(bus.o_read_active), 32'd1);
      end
      repeat (4) tick();
      check_eq("addr_drained", exp_addr_q.size(), 0);
      check_eq("smp_drained", exp_smp_q.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < Depth; i++) mem[i] = SW'(32'hA50000 + i * 32'h1011);
      bus.i_start_read   = 1'b0;
      bus.i_abort        = 1'b0;
      bus.i_trigger_addr = '0;
      bus.i_pretrigger   = '0;
      bus.i_sample_count = '0;
      bus.i_rd           = 1'b0;
      bus.i_ram_data     = '0;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst_n = 1'b1;
      tick();

      run_read(4'd10, 4'd3, 5'd4, 20, 0, 0);
      // Stray consume pulse while idle must not start a read.
      bus.i_rd = 1'b1;
      tick();
      bus.i_rd = 1'b0;
      repeat (3) tick();
      check_eq("idle_rd_ignored", 32'(bus.o_read_active), 32'd0);
      run_read(4'd1,  4'd3, 5'd6,  4, 0, 0);
      run_read(4'd5,  4'd0, 5'd16, 4, 0, 0);
      run_read(4'd9,  4'd2, 5'd0,  4, 0, 0);
      run_read(4'd3,  4'd7, 5'd8,  5, 3, 0);
      run_read(4'd12, 4'd4, 5'd6,  5, 0, 3);
      run_read(4'd2,  4'd5, 5'd3,  6, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
